register_file_mp: RTL and testbench

Parametrised multi-port successor to the single-cycle CPU's 32x32 register file. Adds configurable width, depth and read-port count, plus a second write port for a late writeback path (load / multiply-divide). Adds a per-register busy scoreboard for in-flight producers and optional same-cycle write-to-read bypass. It sits between decode (reads and reservations) and writeback (writes) of the pipelined core.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/register_file_mp.sv | 99 +++++++++
 tb/tb_register_file_mp.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned WR_PORTS = 2;
  localparam int unsigned WP_ALU   = 0;
  localparam int unsigned WP_LATE  = 1;

  function automatic int unsigned idx_width(input int unsigned count);
    return $clog2(count);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by a producer reservation, cleared by writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned IW        = 5,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WR_PORTS-1:0]    write_enable,
  input  logic [WR_PORTS*IW-1:0] write_reg,
  input  logic                   reserve_enable,
  input  logic [IW-1:0]          reserve_reg,
  output logic [REG_COUNT-1:0]   busy
);

  localparam logic [REG_COUNT-1:0] KEEP_MASK = (ZERO_REG != 0) ? ~REG_COUNT'(1) : '1;

  logic [REG_COUNT-1:0] set_vec;
  logic [REG_COUNT-1:0] clr_vec;

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_bit
    assign set_vec[i] = reserve_enable && (reserve_reg == IW'(i));
    assign clr_vec[i] = (write_enable[WP_ALU]  && (write_reg[WP_ALU*IW +: IW]  == IW'(i))) ||
                        (write_enable[WP_LATE] && (write_reg[WP_LATE*IW +: IW] == IW'(i)));
  end

  // A new reservation supersedes a writeback retiring the previous producer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= ((busy & ~clr_vec) | set_vec) & KEEP_MASK;
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with two write ports, busy scoreboard and optional write-to-read bypass.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned V0_INDEX   = 2,
  localparam int unsigned IW        = idx_width(REG_COUNT)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [READ_PORTS*IW-1:0]       read_index,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]          read_busy,
  input  logic [WR_PORTS-1:0]            write_enable,
  input  logic [WR_PORTS*IW-1:0]         write_reg,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] write_data,
  input  logic                           reserve_enable,
  input  logic [IW-1:0]                  reserve_reg,
  output logic [DATA_WIDTH-1:0]          register_v0
);

  localparam logic [IW-1:0] V0_IDX = IW'(V0_INDEX);

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;
  logic [REG_COUNT-1:0]                 busy;

  logic [IW-1:0]         alu_reg, late_reg;
  logic [DATA_WIDTH-1:0] alu_data, late_data;

  assign alu_reg   = write_reg[WP_ALU*IW +: IW];
  assign late_reg  = write_reg[WP_LATE*IW +: IW];
  assign alu_data  = write_data[WP_ALU*DATA_WIDTH +: DATA_WIDTH];
  assign late_data = write_data[WP_LATE*DATA_WIDTH +: DATA_WIDTH];

  regfile_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .IW        (IW),
    .ZERO_REG  (ZERO_REG)
  ) u_scoreboard (
    .clk            (clk),
    .reset_n        (reset_n),
    .write_enable   (write_enable),
    .write_reg      (write_reg),
    .reserve_enable (reserve_enable),
    .reserve_reg    (reserve_reg),
    .busy           (busy)
  );

  // Late port is applied second so it wins an index collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '0;
    end else begin
      if (write_enable[WP_ALU] && (ZERO_REG == 0 || alu_reg != '0))
        regs[alu_reg] <= alu_data;
      if (write_enable[WP_LATE] && (ZERO_REG == 0 || late_reg != '0))
        regs[late_reg] <= late_data;
    end
  end

  assign register_v0 = regs[V0_IDX];

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy_bit;

    assign idx = read_index[p*IW +: IW];

    always_comb begin
      data     = regs[idx];
      busy_bit = busy[idx];
      if (BYPASS != 0) begin
        if (write_enable[WP_ALU] && alu_reg == idx) begin
          data     = alu_data;
          busy_bit = 1'b0;
        end
        if (write_enable[WP_LATE] && late_reg == idx) begin
          data     = late_data;
          busy_bit = 1'b0;
        end
        if (reserve_enable && reserve_reg == idx)
          busy_bit = 1'b1;
      end
      if (ZERO_REG != 0 && idx == '0) begin
        data     = '0;
        busy_bit = 1'b0;
      end
    end

    assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    assign read_busy[p]                          = busy_bit;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed checks of register_file_mp in default, ZERO_REG=0 and narrow/no-bypass configurations.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Default configuration
  logic [9:0]  a_ri = '0;
  logic [63:0] a_rd;
  logic [1:0]  a_rb;
  logic [1:0]  a_we = '0;
  logic [9:0]  a_wr = '0;
  logic [63:0] a_wd = '0;
  logic        a_re = 1'b0;
  logic [4:0]  a_rr = '0;
  logic [31:0] a_v0;

  // ZERO_REG = 0
  logic [9:0]  b_ri = '0;
  logic [63:0] b_rd;
  logic [1:0]  b_rb;
  logic [1:0]  b_we = '0;
  logic [9:0]  b_wr = '0;
  logic [63:0] b_wd = '0;
  logic        b_re = 1'b0;
  logic [4:0]  b_rr = '0;
  logic [31:0] b_v0;

  // 16-bit, 8 registers, 3 read ports, no bypass
  logic [8:0]  c_ri = '0;
  logic [47:0] c_rd;
  logic [2:0]  c_rb;
  logic [1:0]  c_we = '0;
  logic [5:0]  c_wr = '0;
  logic [31:0] c_wd = '0;
  logic        c_re = 1'b0;
  logic [2:0]  c_rr = '0;
  logic [15:0] c_v0;

  register_file_mp u_dut_a (
    .clk(clk), .reset_n(reset_n), .read_index(a_ri), .read_data(a_rd), .read_busy(a_rb),
    .write_enable(a_we), .write_reg(a_wr), .write_data(a_wd),
    .reserve_enable(a_re), .reserve_reg(a_rr), .register_v0(a_v0)
  );

  register_file_mp #(.ZERO_REG(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .read_index(b_ri), .read_data(b_rd), .read_busy(b_rb),
    .write_enable(b_we), .write_reg(b_wr), .write_data(b_wd),
    .reserve_enable(b_re), .reserve_reg(b_rr), .register_v0(b_v0)
  );

  register_file_mp #(
    .DATA_WIDTH(16), .REG_COUNT(8), .READ_PORTS(3), .BYPASS(0), .V0_INDEX(2)
  ) u_dut_c (
    .clk(clk), .reset_n(reset_n), .read_index(c_ri), .read_data(c_rd), .read_busy(c_rb),
    .write_enable(c_we), .write_reg(c_wr), .write_data(c_wd),
    .reserve_enable(c_re), .reserve_reg(c_rr), .register_v0(c_v0)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 reset_n = 1'b1;
    tick();

    // Reset state
    a_ri = {5'd2, 5'd5};
    #1;
    check("rst_a_rd", a_rd, 64'h0);
    check("rst_a_rb", 64'(a_rb), 64'h0);
    check("rst_a_v0", 64'(a_v0), 64'h0);
    check("rst_c_v0", 64'(c_v0), 64'h0);
    tick();

    // Write r5 and r2, then asynchronous reset between edges
    a_we = 2'b11; a_wr = {5'd2, 5'd5}; a_wd = {32'h1234_5678, 32'hDEAD_BEEF};
    tick();
    a_we = '0;
    #1;
    check("wr_r5", 64'(a_rd[31:0]), 64'hDEAD_BEEF);
    check("wr_v0", 64'(a_v0), 64'h1234_5678);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_r5", 64'(a_rd[31:0]), 64'h0);
    check("async_rst_r2", 64'(a_rd[63:32]), 64'h0);
    check("async_rst_busy", 64'(a_rb), 64'h0);
    check("async_rst_v0", 64'(a_v0), 64'h0);
    reset_n = 1'b1;
    tick();

    // Dual-write collision on r7: late port wins
    a_we = 2'b11; a_wr = {5'd7, 5'd7}; a_wd = {32'h22, 32'h11}; a_ri = {5'd0, 5'd7};
    #1;
    check("coll_bypass", 64'(a_rd[31:0]), 64'h22);
    tick();
    a_we = '0;
    #1;
    check("coll_stored", 64'(a_rd[31:0]), 64'h22);

    // Scoreboard on r9
    a_re = 1'b1; a_rr = 5'd9; a_ri = {5'd9, 5'd7};
    #1;
    check("sb_c0_busy_bypass", 64'(a_rb[1]), 64'h1);
    tick();
    a_re = 1'b0;
    #1;
    check("sb_c1_busy", 64'(a_rb[1]), 64'h1);
    tick(); tick();
    check("sb_c3_busy", 64'(a_rb[1]), 64'h1);
    tick();
    a_we = 2'b10; a_wr = {5'd9, 5'd0}; a_wd = {32'h55, 32'h0};
    #1;
    check("sb_c4_data", 64'(a_rd[63:32]), 64'h55);
    check("sb_c4_busy", 64'(a_rb[1]), 64'h0);
    tick();
    a_we = '0;
    #1;
    check("sb_c5_busy", 64'(a_rb[1]), 64'h0);
    check("sb_c5_data", 64'(a_rd[63:32]), 64'h55);
    tick();
    check("sb_c6_busy", 64'(a_rb[1]), 64'h0);

    // Reserve and write r3 in the same cycle: reservation wins
    a_re = 1'b1; a_rr = 5'd3; a_ri = {5'd0, 5'd3};
    tick();
    a_we = 2'b01; a_wr = {5'd0, 5'd3}; a_wd = {32'h0, 32'h33};
    tick();
    a_we = '0; a_re = 1'b0;
    #1;
    check("rsvwr_busy", 64'(a_rb[0]), 64'h1);
    check("rsvwr_data", 64'(a_rd[31:0]), 64'h33);

    // Zero register ignores writes and reservations
    a_we = 2'b01; a_wr = {5'd0, 5'd0}; a_wd = {32'h0, 32'hFFFF_FFFF};
    a_re = 1'b1; a_rr = 5'd0; a_ri = {5'd0, 5'd0};
    #1;
    check("zero_same_rd", a_rd, 64'h0);
    check("zero_same_rb", 64'(a_rb), 64'h0);
    tick();
    a_we = '0; a_re = 1'b0;
    #1;
    check("zero_next_rd", a_rd, 64'h0);
    check("zero_next_rb", 64'(a_rb), 64'h0);

    // ZERO_REG=0: r0 behaves as an ordinary register
    b_we = 2'b01; b_wr = {5'd0, 5'd0}; b_wd = {32'h0, 32'hFFFF_FFFF};
    b_re = 1'b1; b_rr = 5'd0; b_ri = {5'd0, 5'd0};
    #1;
    check("nz_same_rd", b_rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("nz_same_rb", 64'(b_rb), 64'h3);
    tick();
    b_we = '0; b_re = 1'b0;
    #1;
    check("nz_next_rd", b_rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("nz_next_rb", 64'(b_rb), 64'h3);

    // Narrow configuration without bypass
    c_we = 2'b01; c_wr = {3'd0, 3'd6}; c_wd = {16'h0, 16'hABCD}; c_ri = {3'd6, 3'd6, 3'd6};
    #1;
    check("nb_same_rd", 64'(c_rd), 64'h0);
    tick();
    c_we = '0;
    #1;
    check("nb_next_rd", 64'(c_rd), 64'hABCD_ABCD_ABCD);
    c_we = 2'b10; c_wr = {3'd2, 3'd0}; c_wd = {16'h1357, 16'h0};
    c_re = 1'b1; c_rr = 3'd6;
    #1;
    check("nb_v0_before", 64'(c_v0), 64'h0);
    check("nb_rsv_same_rb", 64'(c_rb), 64'h0);
    tick();
    c_we = '0; c_re = 1'b0;
    #1;
    check("nb_v0_after", 64'(c_v0), 64'h1357);
    check("nb_rsv_next_rb", 64'(c_rb), 64'h7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
